// File: rtl/srrc_prac_hb_filter_if.sv
// Sample-stream bundle for the SRRC halfband stage: halfband-rate enable,
// input sample and registered filtered output, all 1s17.
interface srrc_prac_hb_filter_if;
  logic               hb_clk_en;
  logic signed [17:0] x;
  logic signed [17:0] y;

  modport master (output hb_clk_en, output x, input y);
  modport slave  (input hb_clk_en, input x, output y);
endinterface

// File: rtl/srrc_prac_hb_filter.sv
// 15-tap symmetric halfband FIR (1s17 in/out), advanced only on hb_clk_en.
// Define HB_SATURATE_EN to clamp the output instead of wrapping on overflow.
module srrc_prac_hb_filter #(
  parameter logic signed [17:0] C1     = 18'sd40960,
  parameter logic signed [17:0] C3     = -18'sd11264,
  parameter logic signed [17:0] C5     = 18'sd4096,
  parameter logic signed [17:0] C7     = -18'sd1024,
  parameter logic signed [17:0] CENTER = 18'sd65536
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  srrc_prac_hb_filter_if.slave  hb
);

  logic signed [17:0] d_r [15];
  logic signed [17:0] y_r;

  logic signed [18:0] pre_s  [4];
  logic signed [36:0] prod_s [4];
  logic signed [35:0] prod_c_s;
  logic signed [39:0] sum_s;
  logic signed [17:0] y_next_s;

  // Floor shift by 17, then reduce to 18 bits (clamp or two's-complement wrap).
  function automatic logic signed [17:0] reduce_f(input logic signed [39:0] s);
    logic signed [39:0] sh;
    sh = s >>> 17;
`ifdef HB_SATURATE_EN
    if (sh > 40'sd131071) begin
      reduce_f = 18'sh1FFFF;
    end else if (sh < -40'sd131072) begin
      reduce_f = 18'sh20000;
    end else begin
      reduce_f = sh[17:0];
    end
`else
    reduce_f = sh[17:0];
`endif
  endfunction

  // Symmetric pre-add of mirrored taps; odd taps are zero so only four pairs exist.
  always_comb begin
    pre_s[0] = {d_r[0][17], d_r[0]} + {d_r[14][17], d_r[14]};
    pre_s[1] = {d_r[2][17], d_r[2]} + {d_r[12][17], d_r[12]};
    pre_s[2] = {d_r[4][17], d_r[4]} + {d_r[10][17], d_r[10]};
    pre_s[3] = {d_r[6][17], d_r[6]} + {d_r[8][17], d_r[8]};
  end

  // Full-precision products and 40-bit accumulation from the pre-shift line.
  always_comb begin
    prod_s[0] = 37'(pre_s[0]) * 37'(C7);
    prod_s[1] = 37'(pre_s[1]) * 37'(C5);
    prod_s[2] = 37'(pre_s[2]) * 37'(C3);
    prod_s[3] = 37'(pre_s[3]) * 37'(C1);
    prod_c_s  = 36'(d_r[7]) * 36'(CENTER);
    sum_s     = 40'(prod_s[0]) + 40'(prod_s[1]) + 40'(prod_s[2])
              + 40'(prod_s[3]) + 40'(prod_c_s);
    y_next_s  = reduce_f(sum_s);
  end

  // Delay line and output register; reset dominates the enable.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < 15; k++) begin
        d_r[k] <= 18'sd0;
      end
      y_r <= 18'sd0;
    end else if (hb.hb_clk_en) begin
      d_r[0] <= hb.x;
      for (int k = 1; k < 15; k++) begin
        d_r[k] <= d_r[k-1];
      end
      y_r <= y_next_s;
    end else begin
      y_r <= y_r;
    end
  end

  assign hb.y = y_r;

endmodule

// File: tb/tb_srrc_prac_hb_filter.sv
// Scoreboard bench for srrc_prac_hb_filter: directed stimulus pushes expected y per
// enable edge; an independent monitor checks y on every clock.
module tb_srrc_prac_hb_filter;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  srrc_prac_hb_filter_if hb ();

  srrc_prac_hb_filter dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .hb      (hb.slave)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic               chk;
    logic signed [17:0] val;
    string              tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int imp_tab[16] = '{-512, 0, 2048, 0, -5632, 0, 20480, 32768,
                      20480, 0, -5632, 0, 2048, 0, -512, 0};

  // Tap pattern that drives every product to its positive extreme.
  int ovf_tab[15] = '{-131072, 0, 131071, 0, -131072, 0, 131071, 131071,
                      131071, 0, -131072, 0, 131071, 0, -131072};

`ifdef HB_SATURATE_EN
  localparam logic signed [17:0] OVF_EXP = 18'sd131071;
`else
  localparam logic signed [17:0] OVF_EXP = -18'sd81922;
`endif

  task automatic check(input string name, input logic signed [17:0] act,
                       input logic signed [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: y=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset cycles need y=0, enable edges pop the scoreboard, other cycles must hold.
  logic               mon_en, mon_rst, last_ok = 1'b0;
  logic signed [17:0] last_exp = 18'sd0;
  exp_t               e;
  always @(posedge sys_clk) begin
    mon_en  = hb.hb_clk_en;
    mon_rst = reset;
    #1;
    if (mon_rst) begin
      check("reset", hb.y, 18'sd0);
      last_exp = 18'sd0;
      last_ok  = 1'b1;
    end else if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL underflow: enable edge with no expected entry at %0t", $time);
        last_ok = 1'b0;
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check(e.tag, hb.y, e.val);
          last_exp = e.val;
          last_ok  = 1'b1;
        end else begin
          last_ok = 1'b0;
        end
      end
    end else if (last_ok) begin
      check("hold", hb.y, last_exp);
    end
  end

  task automatic step(input logic en, input logic signed [17:0] xv, input logic rv);
    @(negedge sys_clk);
    hb.hb_clk_en = en;
    hb.x         = xv;
    reset        = rv;
  endtask

  task automatic en_push(input logic signed [17:0] xv, input logic c,
                         input logic signed [17:0] v, input string tag);
    exp_t t;
    step(1'b1, xv, 1'b0);
    t.chk = c;
    t.val = v;
    t.tag = tag;
    exp_q.push_back(t);
  endtask

  task automatic gap(input int mode);
    int n;
    n = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, 5)) : 0;
    repeat (n) step(1'b0, 18'sd12345, 1'b0);
  endtask

  task automatic flush();
    repeat (15) en_push(18'sd0, 1'b0, 18'sd0, "flush");
    en_push(18'sd0, 1'b1, 18'sd0, "flush_zero");
  endtask

  task automatic impulse(input int mode, input int n_out);
    en_push(18'sd65536, 1'b1, 18'sd0, "imp_edge");
    for (int i = 0; i < n_out; i++) begin
      gap(mode);
      en_push(18'sd0, 1'b1, 18'(imp_tab[i]), $sformatf("imp%0d_m%0d", i, mode));
    end
  endtask

  initial begin
    hb.hb_clk_en = 1'b0;
    hb.x         = 18'sd0;

    // Reset held with a busy input and toggling enable.
    for (int i = 0; i < 8; i++) begin
      step(((i / 2) % 2) == 1, 18'sd50000, 1'b1);
    end
    en_push(18'sd50000, 1'b1, 18'sd0, "post_reset");
    flush();

    impulse(0, 16);
    impulse(1, 16);
    impulse(2, 16);

    for (int i = 0; i < 15; i++) en_push(18'sd131071, 1'b0, 18'sd0, "dc_fill");
    repeat (2) en_push(18'sd131071, 1'b1, 18'sd131071, "dc_pos");
    for (int i = 0; i < 15; i++) en_push(-18'sd131072, 1'b0, 18'sd0, "dc_fill");
    repeat (2) en_push(-18'sd131072, 1'b1, -18'sd131072, "dc_neg");

    for (int i = 0; i < 15; i++) en_push(18'(ovf_tab[i]), 1'b0, 18'sd0, "ovf_fill");
    en_push(18'sd0, 1'b1, OVF_EXP, "overflow");
    flush();

    // Impulse cut short after its 7th output; reset must wipe the tail.
    impulse(0, 7);
    step(1'b1, 18'sd777, 1'b1);
    step(1'b0, 18'sd0, 1'b1);
    for (int i = 0; i < 16; i++) en_push(18'sd0, 1'b1, 18'sd0, "no_tail");

    step(1'b0, 18'sd0, 1'b0);
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
